// File: rtl/wave_lut_if.sv
// wave_lut_if: sample-source bus between phase stage, quarter-sine ROM and waveform generator
//   s_clk, en, addr, wave_sel, amp : sample strobe and per-sample controls into the generator
//   rom_addr / rom_data            : quarter-wave ROM read port (sync read, 1 clk latency)
//   dout / dout_vld                : scaled signed sample and its 1-clk valid pulse
interface wave_lut_if #(
    parameter int DW     = 16,
    parameter int ROM_AW = 10,
    parameter int AMP_W  = 9
);
    logic              s_clk;
    logic              en;
    logic [11:0]       addr;
    logic [1:0]        wave_sel;
    logic [AMP_W-1:0]  amp;
    logic [ROM_AW-1:0] rom_addr;
    logic [14:0]       rom_data;
    logic [DW-1:0]     dout;
    logic              dout_vld;
    modport master (output s_clk, en, addr, wave_sel, amp, rom_data, input rom_addr, dout, dout_vld);
    modport slave  (input s_clk, en, addr, wave_sel, amp, rom_data, output rom_addr, dout, dout_vld);
endinterface

// File: rtl/wave_lut_gen.sv
// wave_lut_gen: converts a 12-bit phase address into an amplitude-scaled sine/triangle/saw/square sample
//   clk, rst : system clock, synchronous active-high reset
//   bus      : wave_lut_if slave (strobe/controls in, ROM read port, dout/dout_vld out)
module wave_lut_gen #(
    parameter int DW     = 16,
    parameter int ROM_AW = 10,
    parameter int AMP_W  = 9
) (
    input logic       clk,
    input logic       rst,
    wave_lut_if.slave bus
);
    localparam logic signed [26:0] SMAX = 27'(2 ** (DW - 1) - 1);
    localparam logic signed [26:0] SMIN = 27'(-(2 ** (DW - 1)));
    logic [2:0]              sync_q, sync_d;
    logic [3:0]              vld_q, vld_d;
    logic [11:0]             addr0_q, addr0_d, addr1_q, addr1_d, addr2_q, addr2_d;
    logic [1:0]              sel0_q, sel0_d, sel1_q, sel1_d, sel2_q, sel2_d;
    logic [AMP_W-1:0]        amp0_q, amp0_d, amp1_q, amp1_d, amp2_q, amp2_d, amp3_q, amp3_d;
    logic [ROM_AW-1:0]       mag1_q, mag1_d, mag2_q, mag2_d;
    logic signed [16:0]      w3_q, w3_d;
    logic [DW-1:0]           dout_q, dout_d;
    logic                    dout_vld_q, dout_vld_d;
    logic                    cap;
    logic signed [16:0]      mag;
    logic signed [26:0]      p, r;
    always_comb begin
        sync_d     = {sync_q[1:0], bus.s_clk};
        cap        = sync_q[1] & ~sync_q[2] & bus.en;
        vld_d      = {vld_q[2:0], cap};
        addr0_d    = cap ? bus.addr : addr0_q;
        sel0_d     = cap ? bus.wave_sel : sel0_q;
        amp0_d     = cap ? bus.amp : amp0_q;
        // odd quadrants read the quarter table backwards
        mag1_d     = addr0_q[ROM_AW] ? ~addr0_q[ROM_AW-1:0] : addr0_q[ROM_AW-1:0];
        addr1_d    = addr0_q;
        sel1_d     = sel0_q;
        amp1_d     = amp0_q;
        addr2_d    = addr1_q;
        sel2_d     = sel1_q;
        amp2_d     = amp1_q;
        mag2_d     = mag1_q;
        mag        = (sel2_q == 2'd0) ? $signed({2'b0, bus.rom_data}) : $signed({2'b0, mag2_q, mag2_q[9:5]});
        w3_d       = sel2_q[1] ? (sel2_q[0] ? (addr2_q[11] ? -17'sd32767 : 17'sd32767)
                                            : $signed({{2{~addr2_q[11]}}, addr2_q[10:0], 4'b0}))
                               : (addr2_q[11] ? -mag : mag);
        amp3_d     = amp2_q;
        p          = w3_q * $signed({1'b0, amp3_q});
        r          = (p + 27'sd128) >>> 8;
        dout_d     = vld_q[3] ? ((r > SMAX) ? SMAX[DW-1:0] : (r < SMIN) ? SMIN[DW-1:0] : r[DW-1:0]) : dout_q;
        dout_vld_d = vld_q[3];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            // all-ones keeps a high s_clk from looking like a fresh edge once reset releases
            sync_q     <= 3'b111;
            vld_q      <= '0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            addr2_q    <= '0;
            sel0_q     <= '0;
            sel1_q     <= '0;
            sel2_q     <= '0;
            amp0_q     <= '0;
            amp1_q     <= '0;
            amp2_q     <= '0;
            amp3_q     <= '0;
            mag1_q     <= '0;
            mag2_q     <= '0;
            w3_q       <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            vld_q      <= vld_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            sel0_q     <= sel0_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            amp0_q     <= amp0_d;
            amp1_q     <= amp1_d;
            amp2_q     <= amp2_d;
            amp3_q     <= amp3_d;
            mag1_q     <= mag1_d;
            mag2_q     <= mag2_d;
            w3_q       <= w3_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end
    assign bus.rom_addr = mag1_q;
    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
endmodule

// File: tb/tb_wave_lut_gen.sv
// tb_wave_lut_gen: randomized and directed checks of wave_lut_gen against an arithmetic waveform model
module tb_wave_lut_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rom[1024];
    logic signed [15:0] got_v[$], exp_v[$];
    int   got_c[$], exp_c[$];
    wave_lut_if #(.DW(16), .ROM_AW(10), .AMP_W(9)) b();
    wave_lut_gen #(.DW(16), .ROM_AW(10), .AMP_W(9)) dut (.clk(clk), .rst(rst), .bus(b));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) b.rom_data <= 15'(rom[b.rom_addr]);
    always @(negedge clk) if (b.dout_vld === 1'b1) begin
        got_v.push_back(b.dout);
        got_c.push_back(cyc);
    end
    function automatic logic signed [15:0] model(input int a, input int s, input int m);
        int q, idx, mi, w;
        longint pr, r;
        q   = a / 1024;
        idx = a % 1024;
        mi  = (q % 2 == 1) ? 1023 - idx : idx;
        case (s)
            0: w = rom[mi];
            1: w = mi * 32 + mi / 32;
            2: w = a * 16 - 32768;
            default: w = (a >= 2048) ? -32767 : 32767;
        endcase
        if (s < 2 && q >= 2) w = -w;
        pr = longint'(w) * m + 128;
        r  = (pr >= 0) ? pr / 256 : -((-pr + 255) / 256);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction
    task automatic send(input int a, input int s, input int m);
        @(negedge clk);
        b.addr = 12'(a); b.wave_sel = 2'(s); b.amp = 9'(m); b.s_clk = 1'b1;
        exp_v.push_back(model(a, s, m));
        exp_c.push_back(cyc + 7);
        repeat (3) @(negedge clk);
        b.s_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask
    task automatic clear_q();
        got_v.delete(); got_c.delete(); exp_v.delete(); exp_c.delete();
    endtask
    task automatic test_reset();
        b.s_clk = 0; b.en = 1; b.addr = 0; b.wave_sel = 0; b.amp = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b.dout !== 16'd0 || b.dout_vld !== 1'b0 || b.rom_addr !== 10'd0) begin
            n_err++;
            $display("FAIL reset: dout=%h vld=%b rom_addr=%h, want 0/0/0", b.dout, b.dout_vld, b.rom_addr);
        end
        rst = 0;
        repeat (2) @(negedge clk);
    endtask
    task automatic test_sine();
        clear_q();
        send(12'h000, 0, 256);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (b.rom_addr !== 10'd0) begin n_err++; $display("FAIL sine rom_addr 0x000: got %0d want 0", b.rom_addr); end
        send(12'h400, 0, 256);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (b.rom_addr !== 10'd1023) begin n_err++; $display("FAIL sine rom_addr 0x400: got %0d want 1023", b.rom_addr); end
        send(12'hC00, 0, 256);
        send(12'h123, 0, 256);
        send(12'hFFF, 0, 256);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (got_v.size() != exp_v.size()) begin n_err++; $display("FAIL sine count: got %0d want %0d", got_v.size(), exp_v.size()); end
        else foreach (got_v[i]) begin
            n_cmp++;
            if (got_v[i] !== exp_v[i] || got_c[i] !== exp_c[i]) begin
                n_err++;
                $display("FAIL sine #%0d: got %0d @%0d want %0d @%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
            end
        end
    endtask
    task automatic test_square_saw_tri();
        clear_q();
        send(12'h100, 3, 256); send(12'h900, 3, 256);
        send(12'h100, 3, 511); send(12'h900, 3, 511);
        send(12'h100, 3, 0);   send(12'h900, 3, 0);
        send(12'h000, 2, 256); send(12'h800, 2, 256); send(12'hFFF, 2, 256);
        send(12'h3FF, 1, 256); send(12'hC00, 1, 256); send(12'h000, 1, 300);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (got_v.size() != exp_v.size()) begin n_err++; $display("FAIL sqr/saw/tri count: got %0d want %0d", got_v.size(), exp_v.size()); end
        else foreach (got_v[i]) begin
            n_cmp++;
            if (got_v[i] !== exp_v[i] || got_c[i] !== exp_c[i]) begin
                n_err++;
                $display("FAIL sqr/saw/tri #%0d: got %0d @%0d want %0d @%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
            end
        end
        n_cmp++;
        if (exp_v[1] !== -16'sd32767 || exp_v[3] !== -16'sd32768 || exp_v[6] !== -16'sd32768 || exp_v[8] !== 16'sd32752 || exp_v[9] !== 16'sd32767) begin
            n_err++;
            $display("FAIL model anchors: %0d %0d %0d %0d %0d", exp_v[1], exp_v[3], exp_v[6], exp_v[8], exp_v[9]);
        end
    endtask
    task automatic test_mid_reset();
        clear_q();
        @(negedge clk);
        b.addr = 12'h100; b.wave_sel = 3; b.amp = 256; b.s_clk = 1;
        repeat (4) @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b.dout !== 16'd0 || b.dout_vld !== 1'b0) begin
            n_err++;
            $display("FAIL mid reset: dout=%h vld=%b want 0/0", b.dout, b.dout_vld);
        end
        rst = 0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (got_v.size() != 0) begin n_err++; $display("FAIL post-reset pulses: got %0d want 0", got_v.size()); end
        b.s_clk = 0;
        repeat (3) @(negedge clk);
    endtask
    task automatic test_enable();
        clear_q();
        b.en = 0;
        repeat (5) begin
            @(negedge clk); b.s_clk = 1;
            repeat (3) @(negedge clk); b.s_clk = 0;
            repeat (3) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (got_v.size() != 0) begin n_err++; $display("FAIL en=0 pulses: got %0d want 0", got_v.size()); end
        b.en = 1;
        @(negedge clk);
        b.addr = 12'h9AB; b.wave_sel = 1; b.amp = 200; b.s_clk = 1;
        exp_v.push_back(model(12'h9AB, 1, 200));
        exp_c.push_back(cyc + 7);
        repeat (3) @(negedge clk);
        b.en = 0;
        repeat (10) @(negedge clk);
        b.s_clk = 0;
        n_cmp++;
        if (got_v.size() != 1) begin n_err++; $display("FAIL en drop in flight count: got %0d want 1", got_v.size()); end
        else begin
            n_cmp++;
            if (got_v[0] !== exp_v[0] || got_c[0] !== exp_c[0]) begin
                n_err++;
                $display("FAIL en drop in flight: got %0d @%0d want %0d @%0d", got_v[0], got_c[0], exp_v[0], exp_c[0]);
            end
        end
        b.en = 1;
        repeat (3) @(negedge clk);
    endtask
    task automatic test_sel_change();
        clear_q();
        @(negedge clk);
        b.addr = 12'h2C0; b.wave_sel = 0; b.amp = 400; b.s_clk = 1;
        exp_v.push_back(model(12'h2C0, 0, 400));
        exp_c.push_back(cyc + 7);
        repeat (3) @(negedge clk);
        b.wave_sel = 3; b.amp = 128; b.addr = 12'hA00;
        @(negedge clk);
        b.s_clk = 0;
        repeat (2) @(negedge clk);
        send(12'h2C0, 3, 128);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (got_v.size() != 2) begin n_err++; $display("FAIL sel change count: got %0d want 2", got_v.size()); end
        else foreach (got_v[i]) begin
            n_cmp++;
            if (got_v[i] !== exp_v[i] || got_c[i] !== exp_c[i]) begin
                n_err++;
                $display("FAIL sel change #%0d: got %0d @%0d want %0d @%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
            end
        end
    endtask
    task automatic test_random();
        clear_q();
        for (int k = 0; k < 60; k++) send(int'($urandom_range(4095)), int'($urandom_range(3)), int'($urandom_range(511)));
        repeat (10) @(negedge clk);
        n_cmp++;
        if (got_v.size() != exp_v.size()) begin n_err++; $display("FAIL random count: got %0d want %0d", got_v.size(), exp_v.size()); end
        else foreach (got_v[i]) begin
            n_cmp++;
            if (got_v[i] !== exp_v[i] || got_c[i] !== exp_c[i]) begin
                n_err++;
                $display("FAIL random #%0d: got %0d @%0d want %0d @%0d", i, got_v[i], got_c[i], exp_v[i], exp_c[i]);
            end
        end
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $rtoi(32767.0 * $sin((i + 0.5) * 3.14159265358979 / 2048.0) + 0.5);
        test_reset();
        test_sine();
        test_square_saw_tri();
        test_mid_reset();
        test_enable();
        test_sel_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
